// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Transmit back end of the APB UART. Bytes written to THR are queued in a small
// FIFO, or in a single holding slot when the FIFO is disabled. Each byte is
// serialised onto SOUT with 16550 framing: start bit, 5..8 data bits LSB first,
// optional parity, and 1 / 1.5 / 2 stop bits. The baud rate comes from the
// divisor: one bit time is 16*divisor CLK cycles.
//
// Ports
//   CLK, RSTN          clock, asynchronous active-low reset
//   wr_valid_i/data_i  THR write strobe and byte
//   wr_ready_o         space available; writes while low are dropped
//   fifo_en_i          FCR[0]; when 0 the effective depth is 1
//   fifo_clr_i         FCR[2] pulse, flushes queued bytes
//   divisor_i          {DLM,DLL}; 0 stops the bit clock
//   lcr_i              [1:0] wlen, [2] stop, [3] PEN, [4] EPS, [5] stick, [6] break
//   sout_o             serial line, idle high
//   thre_o, temt_o     LSR status bits
//   level_o            number of queued bytes
module uart_tx_serializer #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic                        wr_valid_i,
  input  logic [7:0]                  wr_data_i,
  output logic                        wr_ready_o,
  input  logic                        fifo_en_i,
  input  logic                        fifo_clr_i,
  input  logic [DIV_W-1:0]            divisor_i,
  input  logic [6:0]                  lcr_i,
  output logic                        sout_o,
  output logic                        thre_o,
  output logic                        temt_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level, level_next, limit;
  logic            fifo_en_q, flush, push, pop, thre_q;
  logic [7:0]      head, head_masked;
  logic            head_par;
  logic [DIV_W-1:0] pre_cnt;
  logic            tick16, bit_end;
  logic [4:0]      tick_cnt, tick_next, bit_last;
  logic [2:0]      bit_idx, bit_next, last_data;
  logic [7:0]      shift_q;
  logic            par_q, line_bit;
  logic [5:0]      frame_lcr;

  // The ready limit looks only at the registered level, so a pop in the same
  // cycle does not open up an extra slot. Toggling fifo_en_i flushes the queue.
  assign limit      = fifo_en_i ? DEPTH_L : ONE_L;
  assign wr_ready_o = (level < limit);
  assign flush      = fifo_clr_i | (fifo_en_i ^ fifo_en_q);
  assign push       = wr_valid_i & wr_ready_o & ~flush;
  assign pop        = (state == IDLE) & (level != '0) & ~flush;

  // Parity is worked out from the head byte when it is loaded. Bits above
  // the word length are masked off so that they do not contribute.
  assign head        = mem[rd_ptr];
  assign head_masked = head & (8'hFF >> (2'd3 - lcr_i[1:0]));
  assign head_par    = lcr_i[5] ? ~lcr_i[4]
                                : (lcr_i[4] ? ^head_masked : ~(^head_masked));

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_data_i;
  end

  always_comb begin
    level_next = level;
    if (flush)             level_next = '0;
    else if (push && !pop) level_next = level + ONE_L;
    else if (pop && !push) level_next = level - ONE_L;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      thre_q    <= 1'b1;
      fifo_en_q <= 1'b0;
    end else begin
      fifo_en_q <= fifo_en_i;
      level     <= level_next;
      thre_q    <= (level_next == '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // The prescaler restarts when a frame is loaded, so the start bit is a full
  // 16 ticks long. The >= compare copes with the divisor shrinking mid-count.
  assign tick16 = (divisor_i != '0) && (pre_cnt >= divisor_i - DIV_W'(1));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                  pre_cnt <= '0;
    else if (pop || tick16)     pre_cnt <= '0;
    else if (divisor_i != '0)   pre_cnt <= pre_cnt + DIV_W'(1);
  end

  // The stop bit lasts 16, 24 (1.5 stop bits with a 5-bit word) or 32 ticks.
  // Every other bit lasts 16 ticks.
  always_comb begin
    bit_last = 5'd15;
    if (state == STOP && frame_lcr[2])
      bit_last = (frame_lcr[1:0] == 2'd0) ? 5'd23 : 5'd31;
  end

  assign bit_end   = tick16 && (tick_cnt == bit_last);
  assign last_data = {1'b0, frame_lcr[1:0]} + 3'd4;

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_idx;
    if (state == IDLE) begin
      if (pop) begin
        state_next = START;
        tick_next  = '0;
        bit_next   = '0;
      end
    end else if (tick16) begin
      if (!bit_end) begin
        tick_next = tick_cnt + 5'd1;
      end else begin
        tick_next = '0;
        case (state)
          START:   state_next = DATA;
          DATA: begin
            if (bit_idx == last_data) state_next = frame_lcr[3] ? PARITY : STOP;
            else                      bit_next   = bit_idx + 3'd1;
          end
          PARITY:  state_next = STOP;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  // The frame settings are latched on load. An LCR write during a frame
  // therefore takes effect from the next frame.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      frame_lcr <= '0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      bit_idx  <= bit_next;
      if (pop) begin
        shift_q   <= head;
        par_q     <= head_par;
        frame_lcr <= lcr_i[5:0];
      end else if (state == DATA && bit_end) begin
        shift_q <= {1'b0, shift_q[7:1]};
      end
    end
  end

  // Break is not latched. It pulls the line low at once, and the frame
  // timing keeps running underneath it.
  always_comb begin
    line_bit = 1'b1;
    case (state)
      START:   line_bit = 1'b0;
      DATA:    line_bit = shift_q[0];
      PARITY:  line_bit = par_q;
      default: line_bit = 1'b1;
    endcase
  end

  assign sout_o  = line_bit & ~lcr_i[6];
  assign thre_o  = thre_q;
  assign temt_o  = thre_q && (state == IDLE);
  assign level_o = level;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
// Self-checking bench for uart_tx_serializer. The bench pushes expected bytes
// and parity bits into a scoreboard when it writes them. A software receiver
// decodes SOUT, and each received frame is compared with the scoreboard head.
module tb_uart_tx_serializer;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        fifo_en;
  logic        fifo_clr;
  logic [15:0] divisor;
  logic [6:0]  lcr;
  logic        sout, thre, temt;
  logic [4:0]  level;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;
  exp_t sb[$];

  uart_tx_serializer #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .fifo_en_i(fifo_en), .fifo_clr_i(fifo_clr),
    .divisor_i(divisor), .lcr_i(lcr),
    .sout_o(sout), .thre_o(thre), .temt_o(temt), .level_o(level)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected parity from the 16550 rules, using word-length-masked data.
  function automatic logic exp_parity(input logic [7:0] d, input logic [5:0] l);
    logic x = 1'b0;
    for (int i = 0; i < int'(l[1:0]) + 5; i++) x ^= d[i];
    if (l[5]) return ~l[4];
    return l[4] ? x : ~x;
  endfunction

  function automatic void exp_push(input logic [7:0] d, input logic [5:0] l);
    exp_t e;
    e.data = d & (8'hFF >> (3 - int'(l[1:0])));
    e.par  = exp_parity(d, l);
    sb.push_back(e);
  endfunction

  // One THR write; called and returns on a falling edge.
  task automatic applyStimulus(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge CLK);
    wr_valid = 1'b0;
  endtask

  task automatic wait_temt(input string tag);
    int w = 0;
    while (temt !== 1'b1 && w < 5000) begin
      @(negedge CLK);
      w++;
    end
    if (temt !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s_temt_timeout: temt=%b after %0d cycles, expected 1", tag, temt, w);
    end
  endtask

  // Software receiver: finds the start bit, then samples each bit mid-cell.
  // It returns in the middle of the stop bit.
  task automatic rx_frame(input int bitc, input logic [5:0] l,
                          output logic [7:0] d, output logic p, output logic stop_v,
                          output int start_cyc, output bit to);
    int w = 0;
    d = '0; p = 1'b0; stop_v = 1'b0; start_cyc = 0; to = 1'b0;
    forever begin
      @(negedge CLK);
      if (sout === 1'b0) break;
      w++;
      if (w > 5000) begin
        to = 1'b1;
        return;
      end
    end
    start_cyc = cyc;
    repeat (bitc / 2) @(negedge CLK);
    for (int i = 0; i < int'(l[1:0]) + 5; i++) begin
      repeat (bitc) @(negedge CLK);
      d[i] = sout;
    end
    if (l[3]) begin
      repeat (bitc) @(negedge CLK);
      p = sout;
    end
    repeat (bitc) @(negedge CLK);
    stop_v = sout;
  endtask

  task automatic test_reset;
    RSTN = 1'b0; wr_valid = 1'b0; wr_data = '0; fifo_en = 1'b1; fifo_clr = 1'b0;
    divisor = 16'd1; lcr = 7'h03;
    repeat (3) @(negedge CLK);
    tests_run++; if (sout !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_sout: got %b expected 1", sout); end
    tests_run++; if (thre !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_thre: got %b expected 1", thre); end
    tests_run++; if (temt !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_temt: got %b expected 1", temt); end
    tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 1", wr_ready); end
    tests_run++; if (level !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    RSTN = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_basic_8n1;
    logic [9:0] bits = '0;
    logic mid_temt = 1'bx;
    int j = 0;
    exp_t e;
    divisor = 16'd1; lcr = 7'h03;
    @(negedge CLK);
    exp_push(8'h55, lcr[5:0]);
    applyStimulus(8'h55);
    tests_run++; if (sout !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_pre_start: sout %b expected 1", sout); end
    @(negedge CLK);
    tests_run++; if (sout !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_start_latency: sout %b expected 0", sout); end
    while (temt !== 1'b1 && j < 1000) begin
      if (j < 160 && j % 16 == 8) bits[j/16] = sout;
      if (j == 80) mid_temt = temt;
      @(negedge CLK);
      j++;
    end
    e = sb.pop_front();
    tests_run++; if (j != 160) begin tests_failed++; $display("[TB] FAIL basic_frame_len: %0d cycles expected 160", j); end
    tests_run++; if (bits[8:1] !== e.data) begin tests_failed++; $display("[TB] FAIL basic_data: got %h expected %h", bits[8:1], e.data); end
    tests_run++; if (bits[0] !== 1'b0 || bits[9] !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_framing: start %b stop %b expected 0/1", bits[0], bits[9]); end
    tests_run++; if (mid_temt !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_mid_temt: got %b expected 0", mid_temt); end
  endtask

  task automatic test_fifo_fill;
    int mlev = 0;
    int bad_gap = 0;
    divisor = 16'd1; lcr = 7'h03; fifo_en = 1'b1;
    wait_temt("fill_pre");
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          if (mlev < 16) begin
            exp_push(8'h10 + 8'(i * 7), lcr[5:0]);
            mlev++;
          end
          // The first byte is moved into the idle shifter on the next cycle.
          if (i == 1) mlev--;
          applyStimulus(8'h10 + 8'(i * 7));
        end
        tests_run++; if (level !== 5'(mlev)) begin tests_failed++; $display("[TB] FAIL fill_level: got %0d expected %0d", level, mlev); end
        tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_ready: got %b expected 0", wr_ready); end
      end
      begin
        int prev = 0;
        for (int f = 0; f < 17; f++) begin
          logic [7:0] d; logic p, sv; int sc; bit to;
          exp_t e;
          rx_frame(16, lcr[5:0], d, p, sv, sc, to);
          tests_run++;
          if (to || sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL fill_rx_%0d: timeout=%b queued=%0d, expected a frame", f, to, sb.size());
          end else begin
            e = sb.pop_front();
            if (d !== e.data || sv !== 1'b1) begin
              tests_failed++;
              $display("[TB] FAIL fill_rx_%0d: data %h stop %b expected %h/1", f, d, sv, e.data);
            end
          end
          if (f > 0 && sc - prev != 161) bad_gap++;
          prev = sc;
        end
      end
    join
    tests_run++; if (bad_gap != 0) begin tests_failed++; $display("[TB] FAIL back_to_back_gap: %0d frames not 161 cycles apart, expected 0", bad_gap); end
    wait_temt("fill_post");
    tests_run++; if (sb.size() != 0 || level !== 5'd0) begin tests_failed++; $display("[TB] FAIL fill_drained: queued %0d level %0d expected 0/0", sb.size(), level); end
  endtask

  task automatic test_parity;
    logic [6:0] lcr_tab  [4] = '{7'h1A, 7'h0A, 7'h3A, 7'h2A};
    logic [7:0] data_tab [4] = '{8'h41, 8'h41, 8'h43, 8'h43};
    divisor = 16'd1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d; logic p, sv; int sc; bit to;
      exp_t e;
      wait_temt("parity_pre");
      lcr = lcr_tab[i];
      @(negedge CLK);
      exp_push(data_tab[i], lcr[5:0]);
      applyStimulus(data_tab[i]);
      rx_frame(16, lcr[5:0], d, p, sv, sc, to);
      e = sb.pop_front();
      tests_run++; if (to || d !== e.data) begin tests_failed++; $display("[TB] FAIL parity_data_%0d: got %h expected %h", i, d, e.data); end
      tests_run++; if (to || p !== e.par) begin tests_failed++; $display("[TB] FAIL parity_bit_%0d: got %b expected %b", i, p, e.par); end
    end
  endtask

  task automatic test_stop_len;
    logic [6:0] lcr_tab [2] = '{7'h04, 7'h07};
    int stop_tab [2] = '{48, 64};
    int len_tab  [2] = '{240, 352};
    divisor = 16'd2;
    for (int i = 0; i < 2; i++) begin
      int j = 0, high = 0, w = 0;
      wait_temt("stop_pre");
      lcr = lcr_tab[i];
      @(negedge CLK);
      applyStimulus(8'h00);
      while (sout !== 1'b0 && w < 100) begin
        @(negedge CLK);
        w++;
      end
      while (temt !== 1'b1 && j < 2000) begin
        if (sout === 1'b1) high++; else high = 0;
        @(negedge CLK);
        j++;
      end
      tests_run++; if (high != stop_tab[i]) begin tests_failed++; $display("[TB] FAIL stop_len_%0d: %0d cycles expected %0d", i, high, stop_tab[i]); end
      tests_run++; if (j != len_tab[i]) begin tests_failed++; $display("[TB] FAIL stop_frame_len_%0d: %0d cycles expected %0d", i, j, len_tab[i]); end
    end
  endtask

  task automatic test_clear;
    int zeros = 0;
    divisor = 16'd1; lcr = 7'h03; fifo_en = 1'b1;
    wait_temt("clear_pre");
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i == 0) exp_push(8'h60, lcr[5:0]);
          applyStimulus(8'h60 + 8'(i));
        end
        tests_run++; if (level !== 5'd5) begin tests_failed++; $display("[TB] FAIL clear_level_before: got %0d expected 5", level); end
        repeat (40) @(negedge CLK);
        fifo_clr = 1'b1;
        @(negedge CLK);
        fifo_clr = 1'b0;
        tests_run++; if (level !== 5'd0 || thre !== 1'b1) begin tests_failed++; $display("[TB] FAIL clear_flush: level %0d thre %b expected 0/1", level, thre); end
        tests_run++; if (temt !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear_temt_busy: got %b expected 0", temt); end
      end
      begin
        logic [7:0] d; logic p, sv; int sc; bit to;
        exp_t e;
        rx_frame(16, lcr[5:0], d, p, sv, sc, to);
        e = sb.pop_front();
        tests_run++; if (to || d !== e.data) begin tests_failed++; $display("[TB] FAIL clear_frame: got %h expected %h", d, e.data); end
      end
    join
    wait_temt("clear_post");
    repeat (200) begin
      @(negedge CLK);
      if (sout !== 1'b1) zeros++;
    end
    tests_run++; if (zeros != 0 || temt !== 1'b1) begin tests_failed++; $display("[TB] FAIL clear_no_more_frames: low cycles %0d temt %b expected 0/1", zeros, temt); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d; logic p, sv; int sc; bit to;
    exp_t e;
    divisor = 16'd1; lcr = 7'h03;
    wait_temt("rstmid_pre");
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    repeat (40) @(negedge CLK);
    tests_run++; if (sout !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_in_data: sout %b expected 0", sout); end
    RSTN = 1'b0;
    #1;
    tests_run++; if (sout !== 1'b1 || level !== 5'd0) begin tests_failed++; $display("[TB] FAIL rstmid_async: sout %b level %0d expected 1/0", sout, level); end
    tests_run++; if (temt !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_temt: got %b expected 1", temt); end
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (3) @(negedge CLK);
    exp_push(8'hA5, lcr[5:0]);
    applyStimulus(8'hA5);
    rx_frame(16, lcr[5:0], d, p, sv, sc, to);
    e = sb.pop_front();
    tests_run++; if (to || d !== e.data || sv !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_new_frame: data %h stop %b expected %h/1", d, sv, e.data); end
  endtask

  task automatic test_break;
    int k = 0, bad = 0;
    divisor = 16'd1;
    wait_temt("break_pre");
    lcr = 7'h43;
    @(negedge CLK);
    applyStimulus(8'h55);
    if (sout !== 1'b0) bad++;
    while (temt !== 1'b1 && k < 1000) begin
      @(negedge CLK);
      k++;
      if (sout !== 1'b0) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("[TB] FAIL break_line_low: %0d high samples expected 0", bad); end
    tests_run++; if (k != 161) begin tests_failed++; $display("[TB] FAIL break_temt_timing: %0d cycles expected 161", k); end
    lcr = 7'h03;
    #1;
    tests_run++; if (sout !== 1'b1 || level !== 5'd0) begin tests_failed++; $display("[TB] FAIL break_release: sout %b level %0d expected 1/0", sout, level); end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_fifo_fill();
    test_parity();
    test_stop_len();
    test_clear();
    test_reset_mid();
    test_break();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
